demux32bits_skid: RTL and testbench



---
 rtl/cpu_pkg.sv | 14 +
 rtl/entry_reg.sv | 21 ++
 rtl/demux32bits_skid.sv | 105 ++++++++++
 tb/tb_demux32bits_skid.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants: word width, skid-buffer state encoding and
// destination codes for the 1-to-2 steering buffer.
package cpu_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic DEST_A = 1'b0;
  localparam logic DEST_B = 1'b1;

endpackage

// File: rtl/entry_reg.sv
// One skid-buffer slot: an enabled register with synchronous active-low clear.
module entry_reg #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of block order.
  // NOTE: the storage is cleared on reset even though the state machine
  // already masks stale contents; it keeps the outputs free of old data.
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/demux32bits_skid.sv
// Registered 1-to-2 steering buffer with two-entry skid storage; strict FIFO
// order across both destinations, registered in_ready toward the producer.
module demux32bits_skid
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] OutA,
  output logic             valid_a,
  input  logic             ready_a,
  output logic [WIDTH-1:0] OutB,
  output logic             valid_b,
  input  logic             ready_b
);

  logic [1:0]     state, state_nxt;
  logic           head_en, tail_en;
  logic [WIDTH:0] head_d, head_q, tail_q;
  logic           head_vld, push, pop;

  // Entries are packed as {data, sel}.
  entry_reg #(.W(WIDTH + 1)) u_head (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (head_en),
    .d    (head_d),
    .q    (head_q)
  );

  entry_reg #(.W(WIDTH + 1)) u_tail (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tail_en),
    .d    ({In, sel}),
    .q    (tail_q)
  );

  // Outputs depend only on the head slot and state, never on In/sel.
  assign head_vld = (state == ONE) || (state == FULL);
  assign valid_a  = head_vld && (head_q[0] == DEST_A);
  assign valid_b  = head_vld && (head_q[0] == DEST_B);
  assign OutA     = valid_a ? head_q[WIDTH:1] : '0;
  assign OutB     = valid_b ? head_q[WIDTH:1] : '0;

  assign push = in_valid && in_ready;
  assign pop  = (valid_a && ready_a) || (valid_b && ready_b);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    head_en   = 1'b0;
    tail_en   = 1'b0;
    head_d    = {In, sel};
    case (state)
      EMPTY: begin
        if (push) begin
          state_nxt = ONE;
          head_en   = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_en = 1'b1;
        end else if (push) begin
          state_nxt = FULL;
          tail_en   = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt = ONE;
          head_en   = 1'b1;
          head_d    = tail_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt = EMPTY;
      head_en   = 1'b0;
      tail_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

endmodule

// File: tb/tb_demux32bits_skid.sv
// Bench for demux32bits_skid: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_demux32bits_skid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        sel, in_valid, in_ready, flush;
  logic [31:0] out_a, out_b;
  logic        valid_a, ready_a, valid_b, ready_b;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        sel;
  } ent_t;

  ent_t m_q[$];
  bit   m_ready = 1'b1;

  always #5 clk = ~clk;

  demux32bits_skid #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .In      (in_data),
    .sel     (sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .flush   (flush),
    .OutA    (out_a),
    .valid_a (valid_a),
    .ready_a (ready_a),
    .OutB    (out_b),
    .valid_b (valid_b),
    .ready_b (ready_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded FIFO of at most two words; ready is the
  // registered "not full" view of the queue after each edge.
  always @(posedge clk) begin
    bit m_push, m_pop;
    m_push = in_valid && m_ready;
    m_pop  = (m_q.size() > 0) && (m_q[0].sel ? ready_b : ready_a);
    if (!rst_n || flush) begin
      m_q.delete();
      m_ready = 1'b1;
    end else begin
      if (m_pop)  void'(m_q.pop_front());
      if (m_push) m_q.push_back('{data: in_data, sel: sel});
      m_ready = (m_q.size() < 2);
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_va, e_vb;
      logic [31:0] e_oa, e_ob;
      e_va = (m_q.size() > 0) && !m_q[0].sel;
      e_vb = (m_q.size() > 0) &&  m_q[0].sel;
      e_oa = e_va ? m_q[0].data : 32'h0;
      e_ob = e_vb ? m_q[0].data : 32'h0;
      check("cmp_in_ready", {31'h0, in_ready}, {31'h0, m_ready});
      check("cmp_valid_a",  {31'h0, valid_a},  {31'h0, e_va});
      check("cmp_valid_b",  {31'h0, valid_b},  {31'h0, e_vb});
      check("cmp_out_a",    out_a, e_oa);
      check("cmp_out_b",    out_b, e_ob);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit s);
    in_valid = v;
    in_data  = d;
    sel      = s;
  endtask

  task automatic expect_out(input string tag, input bit va, input logic [31:0] oa,
                            input bit vb, input logic [31:0] ob, input bit rdy);
    check({tag, "_valid_a"},  {31'h0, valid_a},  {31'h0, va});
    check({tag, "_out_a"},    out_a, oa);
    check({tag, "_valid_b"},  {31'h0, valid_b},  {31'h0, vb});
    check({tag, "_out_b"},    out_b, ob);
    check({tag, "_in_ready"}, {31'h0, in_ready}, {31'h0, rdy});
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1);

    // Reset held for two edges with in_valid high.
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    chk_en = 1'b1;
    expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Streaming at full rate.
    drive(1'b1, 32'h1111_1111, 1'b0); tick();
    expect_out("stream1", 1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h2222_2222, 1'b1); tick();
    expect_out("stream2", 1'b0, 32'h0, 1'b1, 32'h2222_2222, 1'b1);
    drive(1'b1, 32'h3333_3333, 1'b0); tick();
    expect_out("stream3", 1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0); tick();
    expect_out("stream_drain", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Backpressure: stalled A head blocks a B word behind it.
    ready_a = 1'b0;
    drive(1'b1, 32'hAAAA_0000, 1'b0); tick();
    drive(1'b1, 32'hBBBB_0000, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0);
    expect_out("bp_full", 1'b1, 32'hAAAA_0000, 1'b0, 32'h0, 1'b0);
    check("bp_model_depth", m_q.size(), 32'd2);
    tick();
    expect_out("bp_hold", 1'b1, 32'hAAAA_0000, 1'b0, 32'h0, 1'b0);
    ready_a = 1'b1;
    tick();
    expect_out("bp_b", 1'b0, 32'h0, 1'b1, 32'hBBBB_0000, 1'b1);
    tick();
    expect_out("bp_drain", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Push and pop together while holding one entry.
    ready_b = 1'b0;
    drive(1'b1, 32'h5, 1'b1); tick();
    ready_b = 1'b1;
    ready_a = 1'b0;
    drive(1'b1, 32'h6, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0);
    expect_out("pushpop", 1'b1, 32'h6, 1'b0, 32'h0, 1'b1);
    check("pushpop_model_depth", m_q.size(), 32'd1);
    ready_a = 1'b1;
    tick();

    // Flush from FULL drops the buffered words and the concurrent input.
    ready_a = 1'b0;
    ready_b = 1'b0;
    drive(1'b1, 32'h7, 1'b0); tick();
    drive(1'b1, 32'h8, 1'b1); tick();
    expect_out("flush_pre", 1'b1, 32'h7, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 32'h9, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    expect_out("flush", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    ready_a = 1'b1;
    ready_b = 1'b1;
    tick();
    tick();
    expect_out("flush_after", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // Reset in the middle of a stalled FULL buffer.
    ready_a = 1'b0;
    ready_b = 1'b0;
    drive(1'b1, 32'hA, 1'b0); tick();
    drive(1'b1, 32'hB, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_out("midreset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'hC, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0);
    expect_out("midreset_push", 1'b0, 32'h0, 1'b1, 32'hC, 1'b1);
    tick();

    // Randomized traffic; the compare process does the checking.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom(), $urandom_range(0, 1) == 1);
      ready_a = ($urandom_range(0, 2) != 0);
      ready_b = ($urandom_range(0, 2) != 0);
      flush   = ($urandom_range(0, 29) == 0);
      rst_n   = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
